// File: rtl/xor_stream_encryptor.sv
// XOR stream encryptor: snapshots a full key and message, then emits the
// ciphertext serially MSB first with the key repeated cyclically.
module xor_stream_encryptor #(
    parameter int MSG_SIZE = 16,
    parameter int KEY_SIZE = 8,
    localparam int MCW = $clog2(MSG_SIZE) + 1,
    localparam int KCW = $clog2(KEY_SIZE) + 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic [KCW-1:0]      iKey_count,
    input  logic [MSG_SIZE-1:0] iMsg,
    input  logic [MCW-1:0]      iMsg_count,
    output logic                oSerial_out,
    output logic                oValid,
    output logic                oBusy,
    output logic                oDone,
    output logic [MCW-1:0]      oBit_counter
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [MSG_SIZE-1:0] msg_q, msg_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [MCW-1:0]      cnt_q, cnt_d;
    logic                serial_q, serial_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic msg_full;
    logic key_full;
    logic start;

    // Counts above full are deliberately not treated as full.
    assign msg_full = (iMsg_count == MCW'(MSG_SIZE));
    assign key_full = (iKey_count == KCW'(KEY_SIZE));
    assign start    = iEn && msg_full && key_full;

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d   = iMsg;
                    key_d   = iKey;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (iEn) begin
                    if (cnt_q == MCW'(MSG_SIZE)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        serial_d = msg_q[MSG_SIZE-1] ^ key_q[KEY_SIZE-1];
                        valid_d  = 1'b1;
                        msg_d    = {msg_q[MSG_SIZE-2:0], 1'b0};
                        key_d    = {key_q[KEY_SIZE-2:0], key_q[KEY_SIZE-1]};
                        cnt_d    = cnt_q + MCW'(1);
                    end
                end
            end
            S_DONE: begin
                // Wait for upstream to re-arm so a full message is sent once.
                if (!msg_full) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oSerial_out  = serial_q;
    assign oValid       = valid_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oBit_counter = cnt_q;

endmodule

// File: tb/tb_xor_stream_encryptor.sv
// Directed bench for xor_stream_encryptor with a queue-based ciphertext
// model checked on every valid output bit.
module tb_xor_stream_encryptor;

    localparam int MSG = 16;
    localparam int KEY = 8;
    localparam int MCW = $clog2(MSG) + 1;
    localparam int KCW = $clog2(KEY) + 1;

    logic           iClk = 1'b0;
    logic           iRst;
    logic           iEn;
    logic [KEY-1:0] iKey;
    logic [KCW-1:0] iKey_count;
    logic [MSG-1:0] iMsg;
    logic [MCW-1:0] iMsg_count;
    logic           oSerial_out;
    logic           oValid;
    logic           oBusy;
    logic           oDone;
    logic [MCW-1:0] oBit_counter;

    int total = 0;
    int bad   = 0;

    logic           exp_q[$];
    logic [MSG-1:0] got_word;
    int             nvalid;

    xor_stream_encryptor #(.MSG_SIZE(MSG), .KEY_SIZE(KEY)) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iEn(iEn),
        .iKey(iKey),
        .iKey_count(iKey_count),
        .iMsg(iMsg),
        .iMsg_count(iMsg_count),
        .oSerial_out(oSerial_out),
        .oValid(oValid),
        .oBusy(oBusy),
        .oDone(oDone),
        .oBit_counter(oBit_counter)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ciphertext bit i straight from the message/key definition.
    function automatic logic cipher_bit(input logic [MSG-1:0] m,
                                        input logic [KEY-1:0] k, input int i);
        return m[MSG-1-i] ^ k[KEY-1-(i % KEY)];
    endfunction

    always @(negedge iClk) begin
        if (iRst && oValid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got bit %0b expected none at %0t",
                         oSerial_out, $time);
            end else begin
                check("stream_bit", 32'(oSerial_out), 32'(exp_q.pop_front()));
                got_word = {got_word[MSG-2:0], oSerial_out};
                nvalid++;
                check("bit_counter", 32'(oBit_counter), 32'(nvalid));
            end
        end
    end

    task automatic step();
        @(negedge iClk);
        #1;
    endtask

    task automatic expect_stream(input logic [MSG-1:0] m, input logic [KEY-1:0] k);
        exp_q.delete();
        got_word = '0;
        nvalid   = 0;
        for (int i = 0; i < MSG; i++) exp_q.push_back(cipher_bit(m, k, i));
    endtask

    task automatic start_stream(input logic [MSG-1:0] m, input logic [KEY-1:0] k);
        iMsg       = m;
        iKey       = k;
        iMsg_count = MCW'(MSG);
        iKey_count = KCW'(KEY);
        iEn        = 1'b1;
        expect_stream(m, k);
    endtask

    task automatic check_latency();
        step();
        check("lat_busy", 32'(oBusy), 32'd1);
        check("lat_novalid", 32'(oValid), 32'd0);
        step();
        check("lat_valid", 32'(oValid), 32'd1);
    endtask

    task automatic wait_valid(input int n);
        int k;
        for (k = 0; k < 100; k++) begin
            if (nvalid >= n) break;
            step();
        end
        if (k == 100) check("wait_valid_timeout", 32'(nvalid), 32'(n));
    endtask

    task automatic wait_done(input logic [MSG-1:0] lit);
        int k;
        for (k = 0; k < 100; k++) begin
            if (oDone) break;
            step();
        end
        if (k == 100) check("wait_done_timeout", 32'(oDone), 32'd1);
        check("word", 32'(got_word), 32'(lit));
        check("nvalid", 32'(nvalid), 32'(MSG));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_cnt", 32'(oBit_counter), 32'(MSG));
        check("done_busy", 32'(oBusy), 32'd0);
        check("done_last", 32'(oSerial_out), 32'(lit[0]));
    endtask

    task automatic rearm();
        iMsg_count = '0;
        step();
        step();
        check("rearm_done", 32'(oDone), 32'd0);
    endtask

    initial begin
        iRst       = 1'b0;
        iEn        = 1'b0;
        iKey       = '0;
        iKey_count = '0;
        iMsg       = '0;
        iMsg_count = '0;
        got_word   = '0;
        nvalid     = 0;
        step();
        step();
        check("rst_serial", 32'(oSerial_out), 32'd0);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_cnt", 32'(oBit_counter), 32'd0);
        iRst = 1'b1;
        step();

        // Basic stream, then hold full without re-encrypting.
        start_stream(16'h1234, 8'hA5);
        check_latency();
        wait_done(16'hB791);
        for (int i = 0; i < 20; i++) begin
            step();
            check("done_hold", 32'(oDone), 32'd1);
        end
        iMsg_count = '0;
        step();
        step();
        check("done_clear", 32'(oDone), 32'd0);
        start_stream(16'h0000, 8'hA5);
        check_latency();
        wait_done(16'hA5A5);
        rearm();

        // Key not full, or over-full: no start.
        iMsg       = 16'h1234;
        iKey       = 8'hA5;
        iMsg_count = MCW'(MSG);
        iKey_count = KCW'(7);
        iEn        = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("k7_busy", 32'(oBusy), 32'd0);
        end
        iKey_count = KCW'(9);
        for (int i = 0; i < 10; i++) begin
            step();
            check("k9_busy", 32'(oBusy), 32'd0);
        end
        start_stream(16'h1234, 8'hA5);
        check_latency();
        wait_done(16'hB791);
        rearm();

        // Stall for three edges after the fifth bit.
        start_stream(16'h1234, 8'hA5);
        wait_valid(5);
        iEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(oValid), 32'd0);
            check("stall_hold", 32'(oSerial_out), 32'd0);
            check("stall_cnt", 32'(oBit_counter), 32'd5);
        end
        iEn = 1'b1;
        wait_done(16'hB791);
        rearm();

        // Reset mid-stream, then a clean restart.
        start_stream(16'h1234, 8'hA5);
        wait_valid(9);
        iRst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 32'(oValid), 32'd0);
        check("mid_rst_busy", 32'(oBusy), 32'd0);
        check("mid_rst_cnt", 32'(oBit_counter), 32'd0);
        check("mid_rst_serial", 32'(oSerial_out), 32'd0);
        check("mid_rst_done", 32'(oDone), 32'd0);
        step();
        expect_stream(16'h1234, 8'hA5);
        iRst = 1'b1;
        check_latency();
        wait_done(16'hB791);
        rearm();

        // Inputs changing mid-stream must not leak into the ciphertext.
        start_stream(16'h1234, 8'hA5);
        wait_valid(3);
        iKey       = 8'hFF;
        iMsg       = 16'hFFFF;
        iKey_count = '0;
        wait_done(16'hB791);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_stream_encryptor.md
Name: xor_stream_encryptor

Overview:
- Downstream consumer of the two deserializers: one holds the key, one holds the message.
- Waits until both bit counters report full, then snapshots key and message.
- Emits ciphertext serially, MSB first: each message bit XORed with the key, with the key repeated cyclically.
- Drives the single-bit encrypted output pin of the design.

Parameters:
- MSG_SIZE, default 16: message width in bits; must be >= 2.
- KEY_SIZE, default 8: key width in bits; must satisfy 2 <= KEY_SIZE <= MSG_SIZE.

Ports:
- iClk, input, 1: system clock, rising edge.
- iRst, input, 1: asynchronous active-low reset.
- iEn, input, 1: global enable; low stalls the shift.
- iKey, input, KEY_SIZE: parallel key from key deserializer.
- iKey_count, input, $clog2(KEY_SIZE)+1: key deserializer bit counter.
- iMsg, input, MSG_SIZE: parallel message from message deserializer.
- iMsg_count, input, $clog2(MSG_SIZE)+1: message deserializer bit counter.
- oSerial_out, output, 1: ciphertext bit.
- oValid, output, 1: oSerial_out carries a new ciphertext bit this cycle.
- oBusy, output, 1: high in SHIFT state.
- oDone, output, 1: full ciphertext emitted.
- oBit_counter, output, $clog2(MSG_SIZE)+1: ciphertext bits emitted, range 0..MSG_SIZE.

Behaviour:
- Reset (iRst low, async): state IDLE. oSerial_out=0, oValid=0, oBusy=0, oDone=0, oBit_counter=0. Internal msg/key snapshots cleared.
- All outputs are registered.
- IDLE:
  - Start condition: iEn=1 && iKey_count==KEY_SIZE && iMsg_count==MSG_SIZE.
  - On a start edge: msg_reg<=iMsg, key_reg<=iKey, oBit_counter<=0, state->SHIFT, oBusy<=1.
  - oValid stays 0 on that edge.
- SHIFT, edge with iEn=1:
  - oSerial_out <= msg_reg[MSG_SIZE-1] ^ key_reg[KEY_SIZE-1].
  - oValid <= 1.
  - msg_reg shifts left by 1; key_reg rotates left by 1, so the key wraps every KEY_SIZE bits.
  - oBit_counter increments.
- SHIFT, edge with iEn=0 (stall):
  - oValid <= 0; all other registers hold.
  - No bit is skipped or duplicated.
- SHIFT end: the edge after the bit that brings oBit_counter to MSG_SIZE (with iEn=1) sets oValid<=0, oBusy<=0, oDone<=1, state->DONE.
  - oBit_counter holds at MSG_SIZE.
  - oSerial_out holds the last bit.
- DONE:
  - oDone stays 1 until iMsg_count != MSG_SIZE (upstream re-armed).
  - On that condition: oDone<=0, state->IDLE.
  - A still-full message is never re-encrypted.
- Latency: first valid bit appears 2 enabled edges after the start condition is sampled. Exactly MSG_SIZE oValid pulses per message.
- Ciphertext bit i (i=0 first) = iMsg[MSG_SIZE-1-i] ^ iKey[KEY_SIZE-1-(i mod KEY_SIZE)].
- Snapshot isolation: changes on iKey/iMsg/counts during SHIFT are ignored.
- Counts above full are treated as not full; no start.
- Reset mid-SHIFT: immediate return to reset values. The partial stream is abandoned; oDone is not asserted.
- Simultaneous start condition and iEn=0: no start; the condition is re-sampled on the next enabled edge.

Test Plan:
- KEY_SIZE=8, MSG_SIZE=16, iKey=0xA5, iMsg=0x1234, both counts full, iEn=1 -> 16 consecutive oValid bits forming 0xB791 MSB first. Then oDone=1, oBit_counter=16.
- Key count 7 while message full, held 50 cycles -> oBusy=0, oValid never asserts. Raise key count to 8 -> stream starts 2 edges later.
- Same data as the first scenario, iEn low for 3 cycles after the 5th bit -> oValid low during the stall, oSerial_out held. Resumed stream still totals 0xB791 with 16 valid bits.
- Pull iRst low after the 9th bit -> all outputs 0 immediately. After release with counts full, the stream restarts from bit 0 with full 0xB791.
- Change iKey to 0xFF mid-stream -> output still 0xB791 (snapshot).
- After DONE, hold message count full 20 cycles -> no second stream. Drop count to 0, refill with iMsg=0x0000 -> stream equals key repeated, 0xA5A5; oDone pulses again.
